// File: rtl/mul16_pkg.sv
// Shared types and constants for the mul16 shift-add multiplier slice.
package mul16_pkg;

   localparam int WIDTH = 16;
   localparam int CNT_W = 4;

   localparam logic [CNT_W-1:0] LAST_CNT = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage : mul16_pkg

// File: rtl/mul16_step.sv
// One shift-add iteration: conditional add of the multiplicand into the upper
// accumulator half, then a right shift of {carry, sum, multiplier} by one.
module mul16_step
   import mul16_pkg::*;
#(
   parameter logic [31:0] UUID  = 32'd0,
   parameter int          WIDTH = mul16_pkg::WIDTH
) (
   input  logic [WIDTH-1:0] i_acc_hi,
   input  logic [WIDTH-1:0] i_mreg,
   input  logic [WIDTH-1:0] i_mcand,
   output logic [WIDTH-1:0] o_acc_hi,
   output logic [WIDTH-1:0] o_mreg
);

   logic [WIDTH-1:0] w_addend;
   logic [WIDTH:0]   w_sum;

   assign w_addend = i_mreg[0] ? i_mcand : '0;

   // 17-bit sum keeps the carry so it can be shifted into the top product bit
   assign w_sum = {1'b0, i_acc_hi} + {1'b0, w_addend};

   assign o_acc_hi = w_sum[WIDTH:1];
   assign o_mreg   = {w_sum[0], i_mreg[WIDTH-1:1]};

endmodule : mul16_step

// File: rtl/mul16_seq_ctrl.sv
// Sequential 16x16 -> 32 unsigned multiplier controller (shift-add, 16 steps).
// Optional build macro MUL16_ZERO_BYPASS_EN: a zero operand skips RUN and
// reports a zero product one cycle after accept.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start
// ST_RUN  | one shift-add step per cycle, 16 cycles
// ST_DONE | product registered, done asserted; start here re-accepts
module mul16_seq_ctrl
#(
   parameter logic [31:0] UUID  = 32'd0,
   parameter              NAME  = "",
   parameter int          WIDTH = mul16_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] i_a_16,
   input  logic [WIDTH-1:0] i_b_16,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] o_prod_lo,
   output logic [WIDTH-1:0] o_prod_hi
);

   import mul16_pkg::*;

   localparam logic [31:0] STEP_UUID = UUID ^ 32'h0000_0001;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]   r_acc_hi;
   logic [WIDTH-1:0]   r_mreg;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_prod_lo;
   logic [WIDTH-1:0]   r_prod_hi;

   logic               w_accept;
   logic               w_zero_op;
   logic               w_last;
   logic [WIDTH-1:0]   w_acc_nxt;
   logic [WIDTH-1:0]   w_mreg_nxt;

`ifdef MUL16_ZERO_BYPASS_EN
   assign w_zero_op = (i_a_16 == '0) || (i_b_16 == '0);
`else
   assign w_zero_op = 1'b0;
`endif

   assign w_last = (r_cnt == LAST_CNT);

   mul16_step #(
      .UUID  (STEP_UUID),
      .WIDTH (WIDTH)
   ) u_step (
      .i_acc_hi (r_acc_hi),
      .i_mreg   (r_mreg),
      .i_mcand  (r_mcand),
      .o_acc_hi (w_acc_nxt),
      .o_mreg   (w_mreg_nxt)
   );

   // Next-state decode; start is only honoured from IDLE or DONE
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = w_zero_op ? ST_DONE : ST_RUN;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (w_last) begin
               w_state_nxt = ST_DONE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Operand capture, iteration registers and product hold registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mcand   <= '0;
         r_acc_hi  <= '0;
         r_mreg    <= '0;
         r_cnt     <= '0;
         r_prod_lo <= '0;
         r_prod_hi <= '0;
      end else if (w_accept) begin
         r_mcand  <= i_a_16;
         r_mreg   <= i_b_16;
         r_acc_hi <= '0;
         r_cnt    <= '0;
         if (w_zero_op) begin
            r_prod_lo <= '0;
            r_prod_hi <= '0;
         end
      end else if (r_state == ST_RUN) begin
         r_acc_hi <= w_acc_nxt;
         r_mreg   <= w_mreg_nxt;
         r_cnt    <= r_cnt + CNT_W'(1);
         if (w_last) begin
            r_prod_hi <= w_acc_nxt;
            r_prod_lo <= w_mreg_nxt;
         end
      end
   end

   assign busy      = (r_state == ST_RUN);
   assign done      = (r_state == ST_DONE);
   assign o_prod_lo = r_prod_lo;
   assign o_prod_hi = r_prod_hi;

endmodule : mul16_seq_ctrl
